// File: rtl/synth_pkg.sv
// Shared synth types: wave-type encodings, allocator FSM states and default note width.
package synth_pkg;

  localparam int NOTE_WIDTH = 7;

  localparam logic [1:0] WAVE_SAW      = 2'd0;
  localparam logic [1:0] WAVE_SQUARE   = 2'd1;
  localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
  localparam logic [1:0] WAVE_NOISE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_APPLY = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/voice_slot.sv
// One oscillator voice's state: gate, note, wave and age.
// Control priority: reset > clear > load > release > age increment.
module voice_slot #(
  parameter int NOTE_W = 7,
  parameter int AGE_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_en,
  input  logic              release_en,
  input  logic              age_inc_en,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [1:0]        wave_in,
  output logic              gate,
  output logic [NOTE_W-1:0] note,
  output logic [1:0]        wave,
  output logic [AGE_W-1:0]  age
);

  logic              gate_q, gate_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [1:0]        wave_q, wave_d;
  logic [AGE_W-1:0]  age_q, age_d;

  always_comb begin
    gate_d = gate_q;
    note_d = note_q;
    wave_d = wave_q;
    age_d  = age_q;
    if (clear) begin
      gate_d = 1'b0;
    end else if (load_en) begin
      gate_d = 1'b1;
      note_d = note_in;
      wave_d = wave_in;
      age_d  = '0;
    end else if (release_en) begin
      gate_d = 1'b0;
    end else if (age_inc_en && age_q != '1) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_q <= 1'b0;
      note_q <= '0;
      wave_q <= '0;
      age_q  <= '0;
    end else begin
      gate_q <= gate_d;
      note_q <= note_d;
      wave_q <= wave_d;
      age_q  <= age_d;
    end
  end

  assign gate = gate_q;
  assign note = note_q;
  assign wave = wave_q;
  assign age  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: sequential scan of all voices, then one apply cycle.
// Define VOICE_ALLOC_STEAL_EN to steal the oldest voice instead of dropping a note-on.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int NOTE_W = NOTE_WIDTH,
  parameter int AGE_W  = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         EvValid,
  output logic                         EvReady,
  input  logic                         EvOn,
  input  logic [NOTE_W-1:0]            EvNote,
  input  logic [1:0]                   EvWave,
  input  logic                         AllOff,
  output logic [VOICES-1:0]            VoiceGate,
  output logic [VOICES-1:0]            VoiceTrig,
  output logic [VOICES*NOTE_W-1:0]     VoiceNote,
  output logic [VOICES*2-1:0]          VoiceWave,
  output logic [$clog2(VOICES+1)-1:0]  ActiveCount,
  output logic                         Dropped
);

  localparam int IDX_W = $clog2(VOICES);
  localparam int CNT_W = $clog2(VOICES+1);

  alloc_state_t      state_q, state_d;
  logic              ev_on_q, ev_on_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  logic [1:0]        ev_wave_q, ev_wave_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              match_found_q, match_found_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic              free_found_q, free_found_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic [IDX_W-1:0]  oldest_idx_q, oldest_idx_d;
  logic [AGE_W-1:0]  oldest_age_q, oldest_age_d;
  logic [VOICES-1:0] trig_q, trig_d;
  logic              dropped_q, dropped_d;

  logic              gate_v [VOICES];
  logic [NOTE_W-1:0] note_v [VOICES];
  logic [1:0]        wave_v [VOICES];
  logic [AGE_W-1:0]  age_v  [VOICES];
  logic [VOICES-1:0] load_v, release_v, inc_v;
  logic [IDX_W-1:0]  sel_idx;
  logic              do_load;
  logic [CNT_W-1:0]  active_cnt;

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
    voice_slot #(.NOTE_W(NOTE_W), .AGE_W(AGE_W)) u_slot (
      .clk        (Clock),
      .rst_n      (Reset),
      .clear      (AllOff),
      .load_en    (load_v[gi]),
      .release_en (release_v[gi]),
      .age_inc_en (inc_v[gi]),
      .note_in    (ev_note_q),
      .wave_in    (ev_wave_q),
      .gate       (gate_v[gi]),
      .note       (note_v[gi]),
      .wave       (wave_v[gi]),
      .age        (age_v[gi])
    );
    assign VoiceGate[gi]                  = gate_v[gi];
    assign VoiceNote[gi*NOTE_W +: NOTE_W] = note_v[gi];
    assign VoiceWave[gi*2 +: 2]           = wave_v[gi];
  end

  always_comb begin
    state_d       = state_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    ev_wave_d     = ev_wave_q;
    idx_d         = idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
    trig_d        = '0;
    dropped_d     = 1'b0;
    load_v        = '0;
    release_v     = '0;
    inc_v         = '0;
    sel_idx       = '0;
    do_load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (EvValid && !AllOff) begin
          ev_on_d       = EvOn;
          ev_note_d     = EvNote;
          ev_wave_d     = EvWave;
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          oldest_idx_d  = '0;
          oldest_age_d  = '0;
          state_d       = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (gate_v[idx_q] && note_v[idx_q] == ev_note_q && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!gate_v[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strict greater-than keeps the lowest index on equal ages.
        if (idx_q == '0 || age_v[idx_q] > oldest_age_q) begin
          oldest_idx_d = idx_q;
          oldest_age_d = age_v[idx_q];
        end
        if (idx_q == IDX_W'(VOICES-1)) state_d = ST_APPLY;
        else                            idx_d   = idx_q + 1'b1;
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        if (ev_on_q) begin
          do_load = 1'b1;
          if (match_found_q)     sel_idx = match_idx_q;
          else if (free_found_q) sel_idx = free_idx_q;
          else begin
`ifdef VOICE_ALLOC_STEAL_EN
            sel_idx = oldest_idx_q;
`else
            do_load   = 1'b0;
            dropped_d = 1'b1;
`endif
          end
          if (do_load) begin
            for (int i = 0; i < VOICES; i++) begin
              if (IDX_W'(i) == sel_idx) begin
                load_v[i] = 1'b1;
                trig_d[i] = 1'b1;
              end else if (gate_v[i]) begin
                inc_v[i] = 1'b1;
              end
            end
          end
        end else begin
          for (int i = 0; i < VOICES; i++)
            release_v[i] = gate_v[i] && (note_v[i] == ev_note_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Panic overrides everything except reset; the latched event is abandoned.
    if (AllOff) begin
      state_d   = ST_IDLE;
      trig_d    = '0;
      dropped_d = 1'b0;
      load_v    = '0;
      release_v = '0;
      inc_v     = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q       <= ST_IDLE;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_wave_q     <= '0;
      idx_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
      trig_q        <= '0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      ev_wave_q     <= ev_wave_d;
      idx_q         <= idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      oldest_idx_q  <= oldest_idx_d;
      oldest_age_q  <= oldest_age_d;
      trig_q        <= trig_d;
      dropped_q     <= dropped_d;
    end
  end

  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < VOICES; i++)
      active_cnt = active_cnt + CNT_W'(gate_v[i]);
  end

  assign EvReady     = (state_q == ST_IDLE) && !AllOff;
  assign VoiceTrig   = trig_q;
  assign ActiveCount = active_cnt;
  // Never set when stealing is enabled, so it stays tied low in that build.
  assign Dropped     = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (VOICES=4); expectations follow VOICE_ALLOC_STEAL_EN.
module tb_voice_allocator;
  import synth_pkg::*;

  localparam int VOICES = 4;
  localparam int NOTE_W = 7;

  logic                Clock = 1'b0;
  logic                Reset = 1'b0;
  logic                EvValid = 1'b0;
  logic                EvReady;
  logic                EvOn = 1'b0;
  logic [NOTE_W-1:0]   EvNote = '0;
  logic [1:0]          EvWave = '0;
  logic                AllOff = 1'b0;
  logic [VOICES-1:0]   VoiceGate;
  logic [VOICES-1:0]   VoiceTrig;
  logic [VOICES*NOTE_W-1:0] VoiceNote;
  logic [VOICES*2-1:0] VoiceWave;
  logic [2:0]          ActiveCount;
  logic                Dropped;

  int tests  = 0;
  int failed = 0;

  always #5 Clock = ~Clock;

  voice_allocator #(.VOICES(VOICES), .NOTE_W(NOTE_W), .AGE_W(4)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .EvValid     (EvValid),
    .EvReady     (EvReady),
    .EvOn        (EvOn),
    .EvNote      (EvNote),
    .EvWave      (EvWave),
    .AllOff      (AllOff),
    .VoiceGate   (VoiceGate),
    .VoiceTrig   (VoiceTrig),
    .VoiceNote   (VoiceNote),
    .VoiceWave   (VoiceWave),
    .ActiveCount (ActiveCount),
    .Dropped     (Dropped)
  );

  // Drives one event from a negedge; returns at the negedge after the APPLY edge.
  task automatic do_event(input logic on, input logic [NOTE_W-1:0] note, input logic [1:0] wave);
    int waited = 0;
    while (EvReady !== 1'b1 && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    tests++;
    if (EvReady !== 1'b1) begin
      failed++;
      $display("FAIL ev_ready_wait got %b want 1", EvReady);
    end
    EvValid = 1'b1;
    EvOn    = on;
    EvNote  = note;
    EvWave  = wave;
    @(posedge Clock);
    @(negedge Clock);
    EvValid = 1'b0;
    EvNote  = 7'h7f;
    EvWave  = 2'd3;
    tests++;
    if (EvReady !== 1'b0) begin
      failed++;
      $display("FAIL ev_ready_busy got %b want 0", EvReady);
    end
    repeat (VOICES) @(posedge Clock);
    tests++;
    if (VoiceTrig !== 4'b0000) begin
      failed++;
      $display("FAIL trig_early got %b want 0000", VoiceTrig);
    end
    @(posedge Clock);
    @(negedge Clock);
    $display("[TB] event on=%0b note=%0d -> gate=%b trig=%b cnt=%0d drop=%b",
             on, note, VoiceGate, VoiceTrig, ActiveCount, Dropped);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    tests++;
    if (VoiceGate !== 4'b0 || VoiceTrig !== 4'b0 || Dropped !== 1'b0) begin
      failed++;
      $display("FAIL reset_pulses gate=%b trig=%b drop=%b want 0", VoiceGate, VoiceTrig, Dropped);
    end
    tests++;
    if (VoiceNote !== '0 || VoiceWave !== '0) begin
      failed++;
      $display("FAIL reset_notes note=%h wave=%h want 0", VoiceNote, VoiceWave);
    end
    tests++;
    if (ActiveCount !== 3'd0 || EvReady !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready cnt=%0d ready=%b want 0/1", ActiveCount, EvReady);
    end
  endtask

  task automatic test_back_to_back();
    do_event(1'b1, 7'd60, WAVE_SAW);
    tests++;
    if (VoiceGate !== 4'b0001 || VoiceTrig !== 4'b0001 || VoiceNote[6:0] !== 7'd60) begin
      failed++;
      $display("FAIL on60 gate=%b trig=%b note0=%0d want 0001/0001/60", VoiceGate, VoiceTrig, VoiceNote[6:0]);
    end
    @(negedge Clock);
    tests++;
    if (VoiceTrig !== 4'b0000) begin
      failed++;
      $display("FAIL trig_pulse got %b want 0000", VoiceTrig);
    end
    do_event(1'b1, 7'd62, WAVE_SQUARE);
    tests++;
    if (VoiceGate !== 4'b0011 || VoiceTrig !== 4'b0010 || VoiceWave[3:2] !== WAVE_SQUARE) begin
      failed++;
      $display("FAIL on62 gate=%b trig=%b wave1=%0d want 0011/0010/1", VoiceGate, VoiceTrig, VoiceWave[3:2]);
    end
    do_event(1'b1, 7'd64, WAVE_TRIANGLE);
    tests++;
    if (VoiceGate !== 4'b0111 || VoiceTrig !== 4'b0100 || ActiveCount !== 3'd3) begin
      failed++;
      $display("FAIL on64 gate=%b trig=%b cnt=%0d want 0111/0100/3", VoiceGate, VoiceTrig, ActiveCount);
    end
    tests++;
    if (VoiceNote !== {7'd0, 7'd64, 7'd62, 7'd60}) begin
      failed++;
      $display("FAIL notes3 got %h want %h", VoiceNote, {7'd0, 7'd64, 7'd62, 7'd60});
    end
  endtask

  task automatic test_retrigger_release();
    do_event(1'b1, 7'd60, WAVE_NOISE);
    tests++;
    if (VoiceTrig !== 4'b0001 || VoiceGate !== 4'b0111 || ActiveCount !== 3'd3 || VoiceWave[1:0] !== WAVE_NOISE) begin
      failed++;
      $display("FAIL retrig gate=%b trig=%b cnt=%0d wave0=%0d want 0111/0001/3/3",
               VoiceGate, VoiceTrig, ActiveCount, VoiceWave[1:0]);
    end
    do_event(1'b0, 7'd62, WAVE_SAW);
    tests++;
    if (VoiceGate !== 4'b0101 || VoiceTrig !== 4'b0000 || ActiveCount !== 3'd2) begin
      failed++;
      $display("FAIL off62 gate=%b trig=%b cnt=%0d want 0101/0000/2", VoiceGate, VoiceTrig, ActiveCount);
    end
    tests++;
    if (VoiceNote[13:7] !== 7'd62) begin
      failed++;
      $display("FAIL off62_note got %0d want 62", VoiceNote[13:7]);
    end
  endtask

  task automatic test_full();
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    for (int n = 60; n < 64; n++) do_event(1'b1, 7'(n), WAVE_SAW);
    tests++;
    if (VoiceGate !== 4'b1111 || ActiveCount !== 3'd4) begin
      failed++;
      $display("FAIL fill gate=%b cnt=%0d want 1111/4", VoiceGate, ActiveCount);
    end
    do_event(1'b1, 7'd64, WAVE_SQUARE);
`ifdef VOICE_ALLOC_STEAL_EN
    tests++;
    if (VoiceTrig !== 4'b0001 || VoiceNote[6:0] !== 7'd64 || Dropped !== 1'b0) begin
      failed++;
      $display("FAIL steal trig=%b note0=%0d drop=%b want 0001/64/0", VoiceTrig, VoiceNote[6:0], Dropped);
    end
    do_event(1'b1, 7'd65, WAVE_SAW);
    tests++;
    if (VoiceTrig !== 4'b0010 || VoiceNote[13:7] !== 7'd65) begin
      failed++;
      $display("FAIL steal2 trig=%b note1=%0d want 0010/65", VoiceTrig, VoiceNote[13:7]);
    end
`else
    tests++;
    if (VoiceTrig !== 4'b0000 || Dropped !== 1'b1 || VoiceNote !== {7'd63, 7'd62, 7'd61, 7'd60}) begin
      failed++;
      $display("FAIL drop trig=%b drop=%b notes=%h want 0000/1/unchanged", VoiceTrig, Dropped, VoiceNote);
    end
    @(negedge Clock);
    tests++;
    if (Dropped !== 1'b0) begin
      failed++;
      $display("FAIL drop_pulse got %b want 0", Dropped);
    end
`endif
    do_event(1'b1, 7'd63, WAVE_TRIANGLE);
    tests++;
    if (VoiceTrig !== 4'b1000 || Dropped !== 1'b0 || VoiceGate !== 4'b1111) begin
      failed++;
      $display("FAIL full_retrig trig=%b drop=%b gate=%b want 1000/0/1111", VoiceTrig, Dropped, VoiceGate);
    end
  endtask

  task automatic test_alloff();
    EvValid = 1'b1;
    EvOn    = 1'b1;
    EvNote  = 7'd70;
    EvWave  = WAVE_SAW;
    @(posedge Clock);
    @(negedge Clock);
    EvValid = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    AllOff = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    AllOff = 1'b0;
    #1;
    tests++;
    if (VoiceGate !== 4'b0000 || ActiveCount !== 3'd0 || VoiceTrig !== 4'b0000 || EvReady !== 1'b1) begin
      failed++;
      $display("FAIL alloff gate=%b cnt=%0d trig=%b ready=%b want 0000/0/0000/1",
               VoiceGate, ActiveCount, VoiceTrig, EvReady);
    end
    repeat (6) @(negedge Clock);
    tests++;
    if (VoiceGate !== 4'b0000 || VoiceTrig !== 4'b0000 || Dropped !== 1'b0) begin
      failed++;
      $display("FAIL alloff_discard gate=%b trig=%b drop=%b want 0", VoiceGate, VoiceTrig, Dropped);
    end
    do_event(1'b1, 7'd50, WAVE_SAW);
    tests++;
    if (VoiceGate !== 4'b0001 || VoiceTrig !== 4'b0001 || VoiceNote[6:0] !== 7'd50) begin
      failed++;
      $display("FAIL after_alloff gate=%b trig=%b note0=%0d want 0001/0001/50", VoiceGate, VoiceTrig, VoiceNote[6:0]);
    end
  endtask

  task automatic test_reset_apply();
    EvValid = 1'b1;
    EvOn    = 1'b1;
    EvNote  = 7'd52;
    @(posedge Clock);
    @(negedge Clock);
    EvValid = 1'b0;
    repeat (VOICES) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    tests++;
    if (VoiceGate !== 4'b0 || VoiceTrig !== 4'b0 || VoiceNote !== '0 || ActiveCount !== 3'd0 || Dropped !== 1'b0) begin
      failed++;
      $display("FAIL reset_apply gate=%b trig=%b note=%h cnt=%0d drop=%b want all 0",
               VoiceGate, VoiceTrig, VoiceNote, ActiveCount, Dropped);
    end
    Reset = 1'b1;
    @(negedge Clock);
    tests++;
    if (EvReady !== 1'b1 || VoiceTrig !== 4'b0) begin
      failed++;
      $display("FAIL reset_apply_ready ready=%b trig=%b want 1/0000", EvReady, VoiceTrig);
    end
    do_event(1'b0, 7'd70, WAVE_SAW);
    tests++;
    if (VoiceGate !== 4'b0 || VoiceTrig !== 4'b0 || VoiceNote !== '0 || Dropped !== 1'b0) begin
      failed++;
      $display("FAIL off_nomatch gate=%b trig=%b note=%h drop=%b want 0", VoiceGate, VoiceTrig, VoiceNote, Dropped);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_retrigger_release();
    test_full();
    test_alloff();
    test_reset_apply();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
